// File: rtl/capture_pkg.sv
// Shared constants and state encoding for the capture enable sequencer and its wrapper.
package capture_pkg;

    localparam int unsigned FCNT_W_DEF      = 16;
    localparam int unsigned TO_W_DEF        = 24;
    localparam int unsigned TIMEOUT_CYC_DEF = 1_000_000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DRAIN   = 2'd3
    } cap_state_e;

endpackage

// File: rtl/capture_ctrl_if.sv
// Host command / camera sideband / capture-enable bundle between CSR logic and capture_ctrl.
interface capture_ctrl_if #(
    parameter int unsigned FCNT_W = capture_pkg::FCNT_W_DEF
);
    logic              cmd_start;
    logic              cmd_stop;
    logic              cmd_abort;
    logic [FCNT_W-1:0] cfg_frames;
    logic              cam_valid;
    logic              cam_sof;
    logic              cap_enable;
    logic              busy;
    logic              done;
    logic              timeout_err;
    logic [FCNT_W-1:0] frames_done;

    modport master (
        output cmd_start, cmd_stop, cmd_abort, cfg_frames, cam_valid, cam_sof,
        input  cap_enable, busy, done, timeout_err, frames_done
    );

    modport slave (
        input  cmd_start, cmd_stop, cmd_abort, cfg_frames, cam_valid, cam_sof,
        output cap_enable, busy, done, timeout_err, frames_done
    );
endinterface

// File: rtl/cap_watchdog.sv
// SOF watchdog: saturating cycle counter, fires after TIMEOUT_CYC running cycles without a clear.
module cap_watchdog #(
    parameter int unsigned TO_W        = 24,
    parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic fire_c
);
    localparam bit              WD_EN    = (TIMEOUT_CYC != 0);
    localparam logic [TO_W-1:0] CNT_MAX  = '1;
    localparam logic [TO_W-1:0] LIMIT_M1 = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] cnt;

    // cnt holds the number of completed running cycles since the last clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (run && cnt != CNT_MAX) begin
            cnt <= cnt + TO_W'(1);
        end
    end

    // Fires in the TIMEOUT_CYC-th running cycle, so busy lasts exactly TIMEOUT_CYC cycles
    assign fire_c = WD_EN && run && (cnt >= LIMIT_M1);

endmodule

// File: rtl/capture_ctrl.sv
// Frame-aligned enable sequencer for the pixel capture stage: burst/continuous, stop, abort, watchdog.
module capture_ctrl
    import capture_pkg::*;
#(
    parameter int unsigned FCNT_W      = FCNT_W_DEF,
    parameter int unsigned TO_W        = TO_W_DEF,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic           clk,
    input  logic           rst,
    capture_ctrl_if.slave  bus
);
    cap_state_e        state;
    logic [FCNT_W-1:0] frames_q;
    logic [FCNT_W-1:0] cfg_q;
    logic              busy_q;
    logic              done_q;
    logic              to_err_q;
    logic              sof_beat;
    logic              count_met;
    logic              wd_run;
    logic              wd_clear;
    logic              wd_fire_c;
    logic              cap_en_c;

    assign sof_beat  = bus.cam_valid & bus.cam_sof;
    assign count_met = (cfg_q != '0) && (frames_q == cfg_q);
    assign wd_run    = (state != ST_IDLE);
    assign wd_clear  = (state == ST_IDLE) | sof_beat;

    cap_watchdog #(
        .TO_W        (TO_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wd (
        .clk    (clk),
        .rst    (rst),
        .clear  (wd_clear),
        .run    (wd_run),
        .fire_c (wd_fire_c)
    );

    // Abort and watchdog override everything; stop beats SOF handling within each state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            to_err_q <= 1'b0;
            frames_q <= '0;
            cfg_q    <= '0;
        end else begin
            done_q   <= 1'b0;
            to_err_q <= 1'b0;
            if (state != ST_IDLE && (bus.cmd_abort || wd_fire_c)) begin
                state    <= ST_IDLE;
                busy_q   <= 1'b0;
                to_err_q <= !bus.cmd_abort;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.cmd_start && !bus.cmd_abort) begin
                            state    <= ST_ARM;
                            busy_q   <= 1'b1;
                            cfg_q    <= bus.cfg_frames;
                            frames_q <= '0;
                        end
                    end
                    ST_ARM: begin
                        if (bus.cmd_stop) begin
                            state  <= ST_IDLE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else if (sof_beat) begin
                            state    <= ST_CAPTURE;
                            frames_q <= FCNT_W'(1);
                        end
                    end
                    ST_CAPTURE: begin
                        // Every SOF seen here is captured, so it is counted even alongside stop
                        if (sof_beat) begin
                            frames_q <= frames_q + FCNT_W'(1);
                        end
                        if (bus.cmd_stop || count_met) begin
                            state <= ST_DRAIN;
                        end
                    end
                    ST_DRAIN: begin
                        if (sof_beat) begin
                            state  <= ST_IDLE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end
                    end
                    default: begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Enable opens on the first SOF beat and closes on the SOF after the last frame
    always_comb begin
        cap_en_c = 1'b0;
        case (state)
            ST_ARM:     cap_en_c = sof_beat;
            ST_CAPTURE: cap_en_c = 1'b1;
            ST_DRAIN:   cap_en_c = !sof_beat;
            default:    cap_en_c = 1'b0;
        endcase
        if (bus.cmd_abort || wd_fire_c) begin
            cap_en_c = 1'b0;
        end
    end

    assign bus.cap_enable  = cap_en_c;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.timeout_err = to_err_q;
    assign bus.frames_done = frames_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl: vector table for short sequences plus frame-level scenarios.
module tb_capture_ctrl;

    localparam int unsigned FW = 16;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp     = 0;
    int   n_bad     = 0;
    int   done_seen = 0;
    int   to_seen   = 0;

    capture_ctrl_if #(.FCNT_W(FW)) bus ();

    capture_ctrl #(
        .FCNT_W      (FW),
        .TO_W        (24),
        .TIMEOUT_CYC (100)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          start, stop, abort, valid, sof;
        logic [FW-1:0] cfg;
        logic          en, busy, done, to;
        logic [FW-1:0] fd;
    } vec_t;

    vec_t vecs [22];

    function automatic vec_t mk(input logic st, sp, ab, v, s, input int cfg,
                                input logic en, b, d, t, input int fd);
        vec_t r;
        r.start = st; r.stop = sp; r.abort = ab; r.valid = v; r.sof = s;
        r.cfg   = FW'(cfg);
        r.en    = en; r.busy = b; r.done = d; r.to = t;
        r.fd    = FW'(fd);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock cycle: drive at the falling edge, settle, then sample before the rising edge
    task automatic drive(input logic st, sp, ab, v, s, input logic [FW-1:0] cfg);
        @(negedge clk);
        bus.cmd_start  = st;
        bus.cmd_stop   = sp;
        bus.cmd_abort  = ab;
        bus.cam_valid  = v;
        bus.cam_sof    = s;
        bus.cfg_frames = cfg;
        #2;
        if (bus.done)        done_seen++;
        if (bus.timeout_err) to_seen++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    // nb beats (SOF on first) plus 2 gap cycles; enable expected exp_en until an abort
    task automatic frame(input string tag, input int nb, input logic exp_en,
                         input int start_at, input int stop_at, input int abort_at);
        for (int b = 0; b < nb + 2; b++) begin
            drive(b == start_at, b == stop_at, b == abort_at, b < nb, b == 0, '0);
            chk($sformatf("%s.b%0d.en", tag, b), 32'(bus.cap_enable),
                32'((abort_at >= 0 && b >= abort_at) ? 1'b0 : exp_en));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int idx;

        //                st sp ab v  s  cfg  en b  d  t  fd
        vecs[0]  = mk(1, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 0, 0, 1,   0, 1, 0, 0, 0);
        vecs[2]  = mk(0, 0, 0, 1, 1, 1,   1, 1, 0, 0, 0);
        vecs[3]  = mk(0, 0, 0, 1, 0, 1,   1, 1, 0, 0, 1);
        vecs[4]  = mk(0, 0, 0, 0, 0, 1,   1, 1, 0, 0, 1);
        vecs[5]  = mk(0, 0, 0, 1, 1, 1,   0, 1, 0, 0, 1);
        vecs[6]  = mk(0, 0, 0, 0, 0, 1,   0, 0, 1, 0, 1);
        vecs[7]  = mk(0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 1);
        vecs[8]  = mk(1, 0, 0, 0, 0, 5,   0, 0, 0, 0, 1);
        vecs[9]  = mk(0, 1, 0, 0, 0, 5,   0, 1, 0, 0, 0);
        vecs[10] = mk(0, 0, 0, 0, 0, 5,   0, 0, 1, 0, 0);
        vecs[11] = mk(1, 0, 1, 0, 0, 5,   0, 0, 0, 0, 0);
        vecs[12] = mk(0, 0, 0, 0, 0, 5,   0, 0, 0, 0, 0);
        vecs[13] = mk(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
        vecs[14] = mk(0, 0, 1, 1, 1, 0,   0, 1, 0, 0, 0);
        vecs[15] = mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
        vecs[16] = mk(1, 0, 0, 0, 0, 2,   0, 0, 0, 0, 0);
        vecs[17] = mk(0, 0, 0, 1, 1, 2,   1, 1, 0, 0, 0);
        vecs[18] = mk(0, 0, 0, 1, 1, 2,   1, 1, 0, 0, 1);
        vecs[19] = mk(0, 0, 0, 1, 0, 2,   1, 1, 0, 0, 2);
        vecs[20] = mk(0, 0, 1, 1, 0, 2,   0, 1, 0, 0, 2);
        vecs[21] = mk(0, 0, 0, 0, 0, 2,   0, 0, 0, 0, 2);

        rst = 1'b1;
        bus.cmd_start = 1'b0; bus.cmd_stop = 1'b0; bus.cmd_abort = 1'b0;
        bus.cam_valid = 1'b0; bus.cam_sof  = 1'b0; bus.cfg_frames = '0;
        repeat (2) @(negedge clk);
        #2;
        chk("rst.en",   32'(bus.cap_enable),  32'd0);
        chk("rst.busy", 32'(bus.busy),        32'd0);
        chk("rst.done", 32'(bus.done),        32'd0);
        chk("rst.to",   32'(bus.timeout_err), 32'd0);
        chk("rst.fd",   32'(bus.frames_done), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Burst of 1, stop in ARM, start+abort, abort in ARM/DRAIN
        for (int i = 0; i < 22; i++) begin
            drive(vecs[i].start, vecs[i].stop, vecs[i].abort, vecs[i].valid, vecs[i].sof, vecs[i].cfg);
            chk($sformatf("v%0d.en", i),   32'(bus.cap_enable),  32'(vecs[i].en));
            chk($sformatf("v%0d.busy", i), 32'(bus.busy),        32'(vecs[i].busy));
            chk($sformatf("v%0d.done", i), 32'(bus.done),        32'(vecs[i].done));
            chk($sformatf("v%0d.to", i),   32'(bus.timeout_err), 32'(vecs[i].to));
            chk($sformatf("v%0d.fd", i),   32'(bus.frames_done), 32'(vecs[i].fd));
        end

        // Burst of 3 over 5 frames
        done_seen = 0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, FW'(3));
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, FW'(3));
        chk("t1.arm_en",   32'(bus.cap_enable), 32'd0);
        chk("t1.arm_busy", 32'(bus.busy),       32'd1);
        for (int f = 1; f <= 5; f++) frame($sformatf("t1.f%0d", f), 16, f <= 3, -1, -1, -1);
        chk("t1.fd",       32'(bus.frames_done), 32'd3);
        chk("t1.busy",     32'(bus.busy),        32'd0);
        chk("t1.done_cnt", 32'(done_seen),       32'd1);

        // Continuous, stop in the middle of frame 10
        done_seen = 0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, FW'(0));
        for (int f = 1; f <= 11; f++)
            frame($sformatf("t2.f%0d", f), 16, f <= 10, -1, (f == 10) ? 8 : -1, -1);
        chk("t2.fd",       32'(bus.frames_done), 32'd10);
        chk("t2.busy",     32'(bus.busy),        32'd0);
        chk("t2.done_cnt", 32'(done_seen),       32'd1);

        // Abort mid-frame 2, then restart clears the count
        done_seen = 0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, FW'(0));
        frame("t3.f1", 16, 1'b1, -1, -1, -1);
        frame("t3.f2", 16, 1'b1, -1, -1, 5);
        chk("t3.busy",     32'(bus.busy),        32'd0);
        chk("t3.fd",       32'(bus.frames_done), 32'd2);
        chk("t3.done_cnt", 32'(done_seen),       32'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, FW'(0));
        idle(1);
        chk("t3.restart_fd",   32'(bus.frames_done), 32'd0);
        chk("t3.restart_busy", 32'(bus.busy),        32'd1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, FW'(0));
        idle(1);
        chk("t3.clean_busy", 32'(bus.busy), 32'd0);

        // Watchdog in ARM: busy for exactly 100 cycles, then a single timeout pulse
        to_seen = 0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, FW'(4));
        for (int i = 0; i < 100; i++) begin
            idle(1);
            if (i == 0)  chk("t4.busy_first", 32'(bus.busy), 32'd1);
            if (i == 99) begin
                chk("t4.busy_last", 32'(bus.busy),        32'd1);
                chk("t4.to_early",  32'(bus.timeout_err), 32'd0);
            end
        end
        idle(1);
        chk("t4.to",   32'(bus.timeout_err), 32'd1);
        chk("t4.busy", 32'(bus.busy),        32'd0);
        chk("t4.fd",   32'(bus.frames_done), 32'd0);
        idle(1);
        chk("t4.to_pulse", 32'(bus.timeout_err), 32'd0);
        chk("t4.to_cnt",   32'(to_seen),         32'd1);

        // Watchdog in CAPTURE: counts from the last SOF, frames_done held
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, FW'(0));
        frame("t4b.f1", 16, 1'b1, -1, -1, -1);
        idx = 18;
        for (int j = 0; j < 200; j++) begin
            idle(1);
            if (bus.timeout_err) break;
            idx++;
        end
        chk("t4b.latency", 32'(idx),            32'd101);
        chk("t4b.fd",      32'(bus.frames_done), 32'd1);
        chk("t4b.busy",    32'(bus.busy),        32'd0);

        // Stop+abort together act as abort; start while busy ignored
        done_seen = 0;
        to_seen   = 0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, FW'(0));
        frame("t5.f1", 16, 1'b1, -1, -1, -1);
        frame("t5.f2", 16, 1'b1, 3, 6, 6);
        chk("t5.fd",       32'(bus.frames_done), 32'd2);
        chk("t5.busy",     32'(bus.busy),        32'd0);
        chk("t5.done_cnt", 32'(done_seen),       32'd0);
        chk("t5.to_cnt",   32'(to_seen),         32'd0);

        // Asynchronous reset mid-frame
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, FW'(0));
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, FW'(0));
        chk("t6.sof_en", 32'(bus.cap_enable), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, FW'(0));
        chk("t6.pre_busy", 32'(bus.busy),        32'd1);
        chk("t6.pre_fd",   32'(bus.frames_done), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("t6.async_en",   32'(bus.cap_enable),  32'd0);
        chk("t6.async_busy", 32'(bus.busy),        32'd0);
        chk("t6.async_fd",   32'(bus.frames_done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle(1);
        chk("t6.post_en",   32'(bus.cap_enable),  32'd0);
        chk("t6.post_busy", 32'(bus.busy),        32'd0);
        chk("t6.post_fd",   32'(bus.frames_done), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
